// File: rtl/j_systolic_array_ws.sv
// j_systolic_array_ws: weight-stationary COLS x ROWS signed MAC array with input/output skew,
// weight-load FSM and a global output stall. Define J_SA_SATURATE_EN to clamp outputs, else they wrap.
//
// state   | meaning
// S_IDLE  | no weight set since reset, inputs refused
// S_LOAD  | accepting ROWS weight beats, one row per beat
// S_RUN   | weights valid, input vectors accepted
// S_DRAIN | reload requested, waiting for in-flight vectors to leave with the old weights

module j_systolic_array_ws #(
    parameter int COLS       = 4,
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WGT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_start,
    input  logic                      wgt_valid,
    output logic                      wgt_ready,
    input  logic [COLS*WGT_WIDTH-1:0] wgt_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COLS*DATA_WIDTH-1:0] in_data,
    input  logic [ROWS*ACC_WIDTH-1:0] in_acc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROWS*OUT_WIDTH-1:0] out_data,
    output logic                      wgt_loaded,
    output logic                      busy
);

    localparam int LATENCY = COLS + ROWS;
    localparam int CNT_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int INF_W   = $clog2(LATENCY + 2);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROWS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          beat_q, beat_d;
    logic                      wgt_loaded_q, wgt_loaded_d;
    logic [INF_W-1:0]          inflight_q, inflight_d;
    logic [WGT_WIDTH-1:0]      w_q [COLS][ROWS];
    logic [WGT_WIDTH-1:0]      w_d [COLS][ROWS];
    logic [LATENCY-1:0]        vld_q, vld_d;
    logic                      out_valid_q, out_valid_d;
    logic [ROWS*OUT_WIDTH-1:0] out_data_q, out_data_d;

    logic stall, adv, in_hs, out_hs, wgt_hs;

    logic [DATA_WIDTH-1:0] d_in    [COLS][ROWS];
    logic [ACC_WIDTH-1:0]  p_in    [ROWS][COLS+1];
    logic [ACC_WIDTH-1:0]  row_res [ROWS];

    assign stall      = out_valid_q & ~out_ready;
    assign adv        = ~stall;
    assign in_ready   = (state_q == S_RUN) & ~stall;
    assign wgt_ready  = (state_q == S_LOAD);
    assign in_hs      = in_valid & in_ready;
    assign out_hs     = out_valid_q & out_ready;
    assign wgt_hs     = wgt_valid & wgt_ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign wgt_loaded = wgt_loaded_q;
    assign busy       = (inflight_q != '0) | (state_q == S_LOAD) | (state_q == S_DRAIN);

    function automatic logic [OUT_WIDTH-1:0] to_out(input logic [ACC_WIDTH-1:0] a);
`ifdef J_SA_SATURATE_EN
        if ((a[ACC_WIDTH-1:OUT_WIDTH-1] == '0) || (a[ACC_WIDTH-1:OUT_WIDTH-1] == '1))
            return a[OUT_WIDTH-1:0];
        else if (a[ACC_WIDTH-1])
            return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
        return a[OUT_WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        wgt_loaded_d = wgt_loaded_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d      = S_LOAD;
                    beat_d       = '0;
                    wgt_loaded_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (wgt_hs) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d      = S_RUN;
                        beat_d       = '0;
                        wgt_loaded_d = 1'b1;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (load_start) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d      = S_LOAD;
                    beat_d       = '0;
                    wgt_loaded_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_d = w_q;
        if (wgt_hs) begin
            for (int i = 0; i < COLS; i++)
                w_d[i][beat_q] = wgt_data[i*WGT_WIDTH +: WGT_WIDTH];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (in_hs && !out_hs)
            inflight_d = inflight_q + INF_W'(1);
        else if (!in_hs && out_hs)
            inflight_d = inflight_q - INF_W'(1);
    end

    // Valid chain and output register move only when the output slot is free.
    always_comb begin
        vld_d       = vld_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            vld_d       = {vld_q[LATENCY-2:0], in_hs};
            out_valid_d = vld_q[LATENCY-1];
            for (int r = 0; r < ROWS; r++)
                out_data_d[r*OUT_WIDTH +: OUT_WIDTH] = to_out(row_res[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            wgt_loaded_q <= 1'b0;
            inflight_q   <= '0;
            w_q          <= '{default: '0};
            vld_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wgt_loaded_q <= wgt_loaded_d;
            inflight_q   <= inflight_d;
            w_q          <= w_d;
            vld_q        <= vld_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // Column i enters row 0 i+1 cycles after the handshake.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col_skew
        logic [DATA_WIDTH-1:0] sk_q [gi+1];
        logic [DATA_WIDTH-1:0] sk_d [gi+1];
        always_comb begin
            sk_d = sk_q;
            if (adv) begin
                sk_d[0] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k <= gi; k++) sk_d[k] = sk_q[k-1];
            end
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) sk_q <= '{default: '0};
            else        sk_q <= sk_d;
        end
        assign d_in[gi][0] = sk_q[gi];
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_seed_skew
        logic [ACC_WIDTH-1:0] sk_q [gr+1];
        logic [ACC_WIDTH-1:0] sk_d [gr+1];
        always_comb begin
            sk_d = sk_q;
            if (adv) begin
                sk_d[0] = in_acc[gr*ACC_WIDTH +: ACC_WIDTH];
                for (int k = 1; k <= gr; k++) sk_d[k] = sk_q[k-1];
            end
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) sk_q <= '{default: '0};
            else        sk_q <= sk_d;
        end
        assign p_in[gr][0] = sk_q[gr];
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_pe_col
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_pe_row
            logic [ACC_WIDTH-1:0] psum_q, psum_d, prod;
            always_comb begin
                prod = {{(ACC_WIDTH-DATA_WIDTH){d_in[gi][gr][DATA_WIDTH-1]}}, d_in[gi][gr]}
                     * {{(ACC_WIDTH-WGT_WIDTH){w_q[gi][gr][WGT_WIDTH-1]}}, w_q[gi][gr]};
                psum_d = adv ? (p_in[gr][gi] + prod) : psum_q;
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) psum_q <= '0;
                else        psum_q <= psum_d;
            end
            assign p_in[gr][gi+1] = psum_q;

            if (gr < ROWS - 1) begin : g_fwd
                logic [DATA_WIDTH-1:0] data_q, data_d;
                always_comb data_d = adv ? d_in[gi][gr] : data_q;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) data_q <= '0;
                    else        data_q <= data_d;
                end
                assign d_in[gi][gr+1] = data_q;
            end
        end
    end

    // Row r finishes r cycles after row 0; delay it so the whole vector lines up.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_deskew
        if (gr == ROWS - 1) begin : g_none
            assign row_res[gr] = p_in[gr][COLS];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] ds_q [ROWS-1-gr];
            logic [ACC_WIDTH-1:0] ds_d [ROWS-1-gr];
            always_comb begin
                ds_d = ds_q;
                if (adv) begin
                    ds_d[0] = p_in[gr][COLS];
                    for (int k = 1; k < ROWS - 1 - gr; k++) ds_d[k] = ds_q[k-1];
                end
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) ds_q <= '{default: '0};
                else        ds_q <= ds_d;
            end
            assign row_res[gr] = ds_q[ROWS-2-gr];
        end
    end

endmodule

// File: tb/tb_j_systolic_array_ws.sv
// Directed bench for j_systolic_array_ws (default 4x4, 8-bit data/weights, 24-bit psum, 16-bit out).
// Expected values are hand constants, or a plain matrix-vector product for the streamed tests.

module tb_j_systolic_array_ws;
    localparam int COLS = 4, ROWS = 4, DW = 8, WW = 8, AW = 24, OW = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 load_start = 1'b0;
    logic                 wgt_valid = 1'b0;
    logic                 wgt_ready;
    logic [COLS*WW-1:0]   wgt_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [COLS*DW-1:0]   in_data = '0;
    logic [ROWS*AW-1:0]   in_acc = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [ROWS*OW-1:0]   out_data;
    logic                 wgt_loaded;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;
    int wm [COLS][ROWS];
    int vd [COLS];
    int va [ROWS];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    j_systolic_array_ws #(
        .COLS(COLS), .ROWS(ROWS), .DATA_WIDTH(DW), .WGT_WIDTH(WW),
        .ACC_WIDTH(AW), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .wgt_loaded(wgt_loaded), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec();
        for (int i = 0; i < COLS; i++) in_data[i*DW +: DW] = DW'(vd[i]);
        for (int r = 0; r < ROWS; r++) in_acc[r*AW +: AW] = AW'(va[r]);
    endtask

    function automatic logic [63:0] exp_vec();
        logic [63:0] res;
        int s;
        res = '0;
        for (int r = 0; r < ROWS; r++) begin
            s = va[r];
            for (int i = 0; i < COLS; i++) s += vd[i] * wm[i][r];
            res[r*OW +: OW] = OW'(s);
        end
        return res;
    endfunction

    task automatic load_w(input bit pulse);
        int n;
        if (pulse) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < COLS; i++) wgt_data[i*WW +: WW] = WW'(wm[i][r]);
            wgt_valid = 1'b1;
            n = 0;
            while (!wgt_ready && n < 100) begin tick(); n++; end
            chk("load_wgt_ready", 64'(wgt_ready), 64'd1);
            if (r == 0) chk("load_loaded_low", 64'(wgt_loaded), 64'd0);
            tick();
        end
        wgt_valid = 1'b0;
        chk("load_loaded_high", 64'(wgt_loaded), 64'd1);
    endtask

    task automatic single(input string tag, input logic [63:0] expv);
        int n;
        set_vec();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_data"}, out_data, expv);
        tick();
        chk({tag, "_valid_clear"}, 64'(out_valid), 64'd0);
    endtask

    task automatic set_identity(input int g);
        for (int i = 0; i < COLS; i++)
            for (int r = 0; r < ROWS; r++) wm[i][r] = (i == r) ? g : 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, cyc, n, cnt;
        logic [63:0] e;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wgt_ready", 64'(wgt_ready), 64'd0);
        chk("rst_wgt_loaded", 64'(wgt_loaded), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd0);

        // Identity weights, plain vector
        set_identity(1);
        load_w(1'b1);
        vd = '{1, 2, 3, 4};
        va = '{0, 0, 0, 0};
        single("t2", {16'd4, 16'd3, 16'd2, 16'd1});

        // Identity with signed seeds and negative data
        vd = '{-1, -2, -3, -4};
        va = '{10, -10, 0, 5};
        single("t3", {16'h0001, 16'hFFFD, 16'hFFF4, 16'h0009});

        // Overflow of OUT_WIDTH: 4*127*127 = 64516
        for (int i = 0; i < COLS; i++)
            for (int r = 0; r < ROWS; r++) wm[i][r] = 127;
        load_w(1'b1);
        vd = '{127, 127, 127, 127};
        va = '{0, 0, 0, 0};
`ifdef J_SA_SATURATE_EN
        single("t5_sat", {4{16'h7FFF}});
`else
        single("t5_wrap", {4{16'hFC04}});
`endif

        // Stream of 32 vectors with random backpressure
        for (int i = 0; i < COLS; i++)
            for (int r = 0; r < ROWS; r++) wm[i][r] = i*3 - r*2 + 1;
        load_w(1'b1);
        sent = 0; recv = 0; cyc = 0;
        exp_q.delete();
        while (recv < 32 && cyc < 3000) begin
            if (sent < 32) begin
                for (int i = 0; i < COLS; i++) vd[i] = ((sent*7 + i*13) % 200) - 100;
                for (int r = 0; r < ROWS; r++) va[r] = sent*100 - r*50 - 1000;
                set_vec();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(exp_vec());
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("t4_spurious", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("t4_data", out_data, e);
                end
                recv++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_recv", 64'(recv), 64'd32);
        tick();
        chk("t4_empty_valid", 64'(out_valid), 64'd0);
        chk("t4_empty_busy", 64'(busy), 64'd0);

        // Reload with 3 vectors in flight: they finish with the old weights
        exp_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < COLS; i++) vd[i] = k*10 - i*7 + 3;
            for (int r = 0; r < ROWS; r++) va[r] = r*11 - k*5;
            set_vec();
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 100) begin tick(); n++; end
            chk("t6_in_ready", 64'(in_ready), 64'd1);
            exp_q.push_back(exp_vec());
            tick();
        end
        in_valid   = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("t6_drain_wgt_ready", 64'(wgt_ready), 64'd0);
        chk("t6_drain_busy", 64'(busy), 64'd1);
        chk("t6_drain_in_ready", 64'(in_ready), 64'd0);
        recv = 0; cyc = 0;
        while (recv < 3 && cyc < 100) begin
            chk("t6_wgt_ready_held", 64'(wgt_ready), 64'd0);
            if (out_valid) begin
                e = exp_q.pop_front();
                chk("t6_old_w_data", out_data, e);
                recv++;
            end
            tick();
            cyc++;
        end
        chk("t6_recv", 64'(recv), 64'd3);
        n = 0;
        while (!wgt_ready && n < 10) begin tick(); n++; end
        chk("t6_drain_to_load", 64'(n), 64'd1);
        chk("t6_loaded_cleared", 64'(wgt_loaded), 64'd0);
        set_identity(2);
        load_w(1'b0);
        vd = '{5, 6, 7, 8};
        va = '{0, 0, 0, 0};
        single("t6_new_w", {16'd16, 16'd14, 16'd12, 16'd10});

        // Reset while a stalled result is held
        out_ready = 1'b0;
        vd = '{1, 1, 1, 1};
        set_vec();
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("t1_stalled_valid", 64'(out_valid), 64'd1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_out_data", out_data, 64'd0);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        chk("t1_wgt_loaded", 64'(wgt_loaded), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        tick();
        chk("t1_wgt_ready", 64'(wgt_ready), 64'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("t1_no_stale_out", 64'(cnt), 64'd0);
        chk("t1_idle_in_ready", 64'(in_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
